// File: rtl/clk_phase_tracker_if.sv
// Bus between a clk_phase_tracker and its surroundings: the divided clock in,
// the recovered phase, lock and error status out.
interface clk_phase_tracker_if #(
    parameter int DSR   = 4,
    parameter int ERR_W = 8
);
    localparam int CW = (DSR > 1) ? $clog2(DSR) : 1;

    logic          slowIn;
    logic [CW-1:0] cntOut;
    logic          strobe;
    logic          locked;
    logic          errPulse;
    logic [ERR_W-1:0] errCount;

    modport master (
        output slowIn,
        input  cntOut, strobe, locked, errPulse, errCount
    );

    modport slave (
        input  slowIn,
        output cntOut, strobe, locked, errPulse, errCount
    );
endinterface

// File: rtl/clk_phase_tracker.sv
// Recovers the phase counter of a divided clock sampled in the clk domain,
// tracks phase lock and counts period/duty violations.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// UNLOCKED | waiting for a rise; no checks
// ACQUIRE  | aligned to a rise; counting on-time rises up to LOCK_CNT
// LOCKED   | LOCK_CNT consecutive on-time rises seen; locked asserted
module clk_phase_tracker #(
    parameter int DSR      = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic clk,
    input  logic rst,
    clk_phase_tracker_if.slave bus
);
    localparam int CW = (DSR > 1) ? $clog2(DSR) : 1;

    logic [CW-1:0]    cnt;
    logic             strobeR;
    logic             lockedR;
    logic             errPulseR;
    logic [ERR_W-1:0] errCountR;

    assign bus.cntOut   = cnt;
    assign bus.strobe   = strobeR;
    assign bus.locked   = lockedR;
    assign bus.errPulse = errPulseR;
    assign bus.errCount = errCountR;

    generate
        if (DSR == 1) begin : g_bypass
            // A ratio of one carries no phase information: permanently locked.
            logic unused_slow;
            assign unused_slow = bus.slowIn;
            assign cnt         = '0;
            assign errPulseR   = 1'b0;
            assign errCountR   = '0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lockedR <= 1'b0;
                    strobeR <= 1'b0;
                end else begin
                    lockedR <= 1'b1;
                    strobeR <= 1'b1;
                end
            end
        end else begin : g_track
            localparam int H  = DSR / 2;
            localparam int GW = $clog2(LOCK_CNT + 1);
            localparam logic [CW-1:0] LAST    = CW'(DSR - 1);
            localparam logic [CW-1:0] DUTY_AT = CW'(H - 1);

            typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

            state_t        state, stateNxt;
            logic [GW-1:0] goodCnt, goodNxt;
            logic [CW-1:0] cntNxt;
            logic          sPrev;
            logic          rise, fall, atEnd;
            logic          early, missing, dutyErr, violation;

            always_comb begin
                rise      = bus.slowIn & ~sPrev;
                fall      = ~bus.slowIn & sPrev;
                atEnd     = (cnt == LAST);
                early     = rise & ~atEnd;
                missing   = atEnd & ~rise;
                dutyErr   = fall & (cnt != DUTY_AT);
                cntNxt    = (rise || atEnd) ? '0 : cnt + 1'b1;
                stateNxt  = state;
                goodNxt   = goodCnt;
                violation = 1'b0;

                case (state)
                    UNLOCKED: begin
                        if (rise) begin
                            stateNxt = ACQUIRE;
                            goodNxt  = '0;
                        end
                    end
                    ACQUIRE, LOCKED: begin
                        // Missing rise outranks a coincident duty error.
                        if (missing) begin
                            violation = 1'b1;
                            stateNxt  = UNLOCKED;
                            goodNxt   = '0;
                        end else if (early || dutyErr) begin
                            violation = 1'b1;
                            stateNxt  = ACQUIRE;
                            goodNxt   = '0;
                        end else if (rise && state == ACQUIRE) begin
                            goodNxt = goodCnt + 1'b1;
                            if (goodCnt == GW'(LOCK_CNT - 1))
                                stateNxt = LOCKED;
                        end
                    end
                    default: begin
                        stateNxt = UNLOCKED;
                        goodNxt  = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state     <= UNLOCKED;
                    goodCnt   <= '0;
                    sPrev     <= 1'b1;
                    cnt       <= '0;
                    lockedR   <= 1'b0;
                    strobeR   <= 1'b0;
                    errPulseR <= 1'b0;
                    errCountR <= '0;
                end else begin
                    state     <= stateNxt;
                    goodCnt   <= goodNxt;
                    sPrev     <= bus.slowIn;
                    cnt       <= cntNxt;
                    lockedR   <= (stateNxt == LOCKED);
                    strobeR   <= (stateNxt == LOCKED) && (cntNxt == '0);
                    errPulseR <= violation;
                    if (violation && (errCountR != '1))
                        errCountR <= errCountR + 1'b1;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_clk_phase_tracker.sv
// Directed self-checking bench for clk_phase_tracker (DSR=4 and DSR=1 instances).
module tb_clk_phase_tracker;
    logic clk = 1'b0;
    logic rst;
    logic rst1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    clk_phase_tracker_if #(.DSR(4), .ERR_W(4)) bus4 ();
    clk_phase_tracker_if #(.DSR(1), .ERR_W(4)) bus1 ();

    clk_phase_tracker #(.DSR(4), .LOCK_CNT(3), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    clk_phase_tracker #(.DSR(1), .LOCK_CNT(3), .ERR_W(4)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );

    task automatic step(input logic v);
        bus4.slowIn = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus4.slowIn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Three idle edges, then four clean 2/2 periods; rise at i=4, lock after i=16.
    task automatic lock_up();
        logic v;
        for (int i = 1; i <= 19; i++) begin
            v = (i > 3) && (((i - 4) % 4) < 2);
            step(v);
            if (i == 15) begin
                tests++; if (bus4.locked !== 1'b0) begin fails++; $display("FAIL acq_early_lock: got %0b expected 0", bus4.locked); end
            end
            if (i == 16) begin
                tests++; if (bus4.locked !== 1'b1) begin fails++; $display("FAIL acq_lock: got %0b expected 1", bus4.locked); end
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests++; if (bus4.cntOut !== 2'd0)   begin fails++; $display("FAIL rst_cnt: got %0d expected 0", bus4.cntOut); end
        tests++; if (bus4.strobe !== 1'b0)   begin fails++; $display("FAIL rst_strobe: got %0b expected 0", bus4.strobe); end
        tests++; if (bus4.locked !== 1'b0)   begin fails++; $display("FAIL rst_locked: got %0b expected 0", bus4.locked); end
        tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL rst_pulse: got %0b expected 0", bus4.errPulse); end
        tests++; if (bus4.errCount !== 4'd0) begin fails++; $display("FAIL rst_errcnt: got %0d expected 0", bus4.errCount); end
        tests++; if (bus1.locked !== 1'b0)   begin fails++; $display("FAIL rst1_locked: got %0b expected 0", bus1.locked); end
        tests++; if (bus1.strobe !== 1'b0)   begin fails++; $display("FAIL rst1_strobe: got %0b expected 0", bus1.strobe); end
        // slowIn already high at release must not realign the counter.
        bus4.slowIn = 1'b1;
        rst = 1'b0;
        step(1'b1);
        tests++; if (bus4.cntOut !== 2'd1) begin fails++; $display("FAIL rst_high_norise: got %0d expected 1", bus4.cntOut); end
        step(1'b1);
        tests++; if (bus4.cntOut !== 2'd2) begin fails++; $display("FAIL rst_high_norise2: got %0d expected 2", bus4.cntOut); end
    endtask

    task automatic test_clean_lock();
        int   expCnt;
        logic v, expLock, expStrobe;
        do_reset();
        for (int e = 1; e <= 33; e++) begin
            v = (e >= 10) && (((e - 10) % 4) < 2);
            step(v);
            expCnt    = (e < 10) ? (e % 4) : ((e - 10) % 4);
            expLock   = (e >= 22);
            expStrobe = (e >= 22) && (((e - 10) % 4) == 0);
            tests++; if (bus4.cntOut !== 2'(expCnt))   begin fails++; $display("FAIL clean_cnt edge %0d: got %0d expected %0d", e, bus4.cntOut, expCnt); end
            tests++; if (bus4.locked !== expLock)     begin fails++; $display("FAIL clean_locked edge %0d: got %0b expected %0b", e, bus4.locked, expLock); end
            tests++; if (bus4.strobe !== expStrobe)   begin fails++; $display("FAIL clean_strobe edge %0d: got %0b expected %0b", e, bus4.strobe, expStrobe); end
            tests++; if (bus4.errPulse !== 1'b0)      begin fails++; $display("FAIL clean_pulse edge %0d: got %0b expected 0", e, bus4.errPulse); end
        end
        tests++; if (bus4.errCount !== 4'd0) begin fails++; $display("FAIL clean_errcnt: got %0d expected 0", bus4.errCount); end
    endtask

    task automatic test_early_rise();
        logic v;
        do_reset();
        lock_up();
        step(1'b1); step(1'b1); step(1'b0);
        step(1'b1);
        tests++; if (bus4.errPulse !== 1'b1) begin fails++; $display("FAIL early_pulse: got %0b expected 1", bus4.errPulse); end
        tests++; if (bus4.errCount !== 4'd1) begin fails++; $display("FAIL early_errcnt: got %0d expected 1", bus4.errCount); end
        tests++; if (bus4.locked !== 1'b0)   begin fails++; $display("FAIL early_locked: got %0b expected 0", bus4.locked); end
        tests++; if (bus4.cntOut !== 2'd0)   begin fails++; $display("FAIL early_cnt: got %0d expected 0", bus4.cntOut); end
        for (int i = 1; i <= 15; i++) begin
            v = ((i % 4) < 2);
            step(v);
            if (i == 1) begin
                tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL early_pulse_len: got %0b expected 0", bus4.errPulse); end
            end
            if (i == 11) begin
                tests++; if (bus4.locked !== 1'b0) begin fails++; $display("FAIL early_relock_soon: got %0b expected 0", bus4.locked); end
            end
            if (i == 12) begin
                tests++; if (bus4.locked !== 1'b1) begin fails++; $display("FAIL early_relock: got %0b expected 1", bus4.locked); end
            end
        end
        tests++; if (bus4.errCount !== 4'd1) begin fails++; $display("FAIL early_errcnt_end: got %0d expected 1", bus4.errCount); end
    endtask

    task automatic test_missing_rise();
        logic v;
        do_reset();
        lock_up();
        for (int i = 0; i <= 22; i++) begin
            v = (i < 2) || ((i >= 10) && (((i - 10) % 4) < 2));
            step(v);
            if (i == 3) begin
                tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL miss_pre_pulse: got %0b expected 0", bus4.errPulse); end
                tests++; if (bus4.locked !== 1'b1)   begin fails++; $display("FAIL miss_pre_locked: got %0b expected 1", bus4.locked); end
            end
            if (i == 4) begin
                tests++; if (bus4.errPulse !== 1'b1) begin fails++; $display("FAIL miss_pulse: got %0b expected 1", bus4.errPulse); end
                tests++; if (bus4.errCount !== 4'd1) begin fails++; $display("FAIL miss_errcnt: got %0d expected 1", bus4.errCount); end
                tests++; if (bus4.locked !== 1'b0)   begin fails++; $display("FAIL miss_locked: got %0b expected 0", bus4.locked); end
            end
            if (i == 5) begin
                tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL miss_pulse_len: got %0b expected 0", bus4.errPulse); end
            end
            if (i == 10) begin
                tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL miss_reacq_pulse: got %0b expected 0", bus4.errPulse); end
                tests++; if (bus4.cntOut !== 2'd0)   begin fails++; $display("FAIL miss_reacq_cnt: got %0d expected 0", bus4.cntOut); end
            end
            if (i == 21) begin
                tests++; if (bus4.locked !== 1'b0) begin fails++; $display("FAIL miss_relock_soon: got %0b expected 0", bus4.locked); end
            end
            if (i == 22) begin
                tests++; if (bus4.locked !== 1'b1) begin fails++; $display("FAIL miss_relock: got %0b expected 1", bus4.locked); end
            end
        end
        tests++; if (bus4.errCount !== 4'd1) begin fails++; $display("FAIL miss_errcnt_end: got %0d expected 1", bus4.errCount); end
    endtask

    task automatic test_duty_error();
        do_reset();
        lock_up();
        step(1'b1); step(1'b1); step(1'b1);
        tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL duty_pre_pulse: got %0b expected 0", bus4.errPulse); end
        tests++; if (bus4.locked !== 1'b1)   begin fails++; $display("FAIL duty_pre_locked: got %0b expected 1", bus4.locked); end
        step(1'b0);
        tests++; if (bus4.errPulse !== 1'b1) begin fails++; $display("FAIL duty_pulse: got %0b expected 1", bus4.errPulse); end
        tests++; if (bus4.errCount !== 4'd1) begin fails++; $display("FAIL duty_errcnt: got %0d expected 1", bus4.errCount); end
        tests++; if (bus4.locked !== 1'b0)   begin fails++; $display("FAIL duty_locked: got %0b expected 0", bus4.locked); end
        tests++; if (bus4.cntOut !== 2'd3)   begin fails++; $display("FAIL duty_cnt_runs: got %0d expected 3", bus4.cntOut); end
        step(1'b1);
        tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL duty_pulse_len: got %0b expected 0", bus4.errPulse); end
        tests++; if (bus4.cntOut !== 2'd0)   begin fails++; $display("FAIL duty_next_rise: got %0d expected 0", bus4.cntOut); end
        tests++; if (bus4.errCount !== 4'd1) begin fails++; $display("FAIL duty_errcnt_hold: got %0d expected 1", bus4.errCount); end
    endtask

    task automatic test_saturation();
        int expCnt;
        do_reset();
        lock_up();
        step(1'b1); step(1'b1); step(1'b0);
        for (int n = 1; n <= 20; n++) begin
            step(1'b1);
            expCnt = (n < 15) ? n : 15;
            tests++; if (bus4.errPulse !== 1'b1)         begin fails++; $display("FAIL sat_pulse n=%0d: got %0b expected 1", n, bus4.errPulse); end
            tests++; if (bus4.errCount !== 4'(expCnt))  begin fails++; $display("FAIL sat_errcnt n=%0d: got %0d expected %0d", n, bus4.errCount, expCnt); end
            step(1'b1);
            tests++; if (bus4.errPulse !== 1'b0)         begin fails++; $display("FAIL sat_pulse_len n=%0d: got %0b expected 0", n, bus4.errPulse); end
            step(1'b0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lock_up();
        step(1'b1); step(1'b1);
        tests++; if (bus4.locked !== 1'b1) begin fails++; $display("FAIL arst_pre_locked: got %0b expected 1", bus4.locked); end
        tests++; if (bus4.cntOut !== 2'd1) begin fails++; $display("FAIL arst_pre_cnt: got %0d expected 1", bus4.cntOut); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus4.locked !== 1'b0)   begin fails++; $display("FAIL arst_locked: got %0b expected 0", bus4.locked); end
        tests++; if (bus4.cntOut !== 2'd0)   begin fails++; $display("FAIL arst_cnt: got %0d expected 0", bus4.cntOut); end
        tests++; if (bus4.strobe !== 1'b0)   begin fails++; $display("FAIL arst_strobe: got %0b expected 0", bus4.strobe); end
        tests++; if (bus4.errPulse !== 1'b0) begin fails++; $display("FAIL arst_pulse: got %0b expected 0", bus4.errPulse); end
        tests++; if (bus4.errCount !== 4'd0) begin fails++; $display("FAIL arst_errcnt: got %0d expected 0", bus4.errCount); end
        @(posedge clk); #1;
        rst = 1'b0;
        lock_up();
    endtask

    task automatic test_dsr1();
        logic v;
        tests++; if (bus1.locked !== 1'b0) begin fails++; $display("FAIL dsr1_rst_locked: got %0b expected 0", bus1.locked); end
        rst1 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            v = (i % 3) == 0;
            bus1.slowIn = v;
            @(posedge clk); #1;
            tests++; if (bus1.locked !== 1'b1)   begin fails++; $display("FAIL dsr1_locked i=%0d: got %0b expected 1", i, bus1.locked); end
            tests++; if (bus1.strobe !== 1'b1)   begin fails++; $display("FAIL dsr1_strobe i=%0d: got %0b expected 1", i, bus1.strobe); end
            tests++; if (bus1.cntOut !== 1'b0)   begin fails++; $display("FAIL dsr1_cnt i=%0d: got %0d expected 0", i, bus1.cntOut); end
            tests++; if (bus1.errPulse !== 1'b0) begin fails++; $display("FAIL dsr1_pulse i=%0d: got %0b expected 0", i, bus1.errPulse); end
            tests++; if (bus1.errCount !== 4'd0) begin fails++; $display("FAIL dsr1_errcnt i=%0d: got %0d expected 0", i, bus1.errCount); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        rst1        = 1'b1;
        bus4.slowIn = 1'b0;
        bus1.slowIn = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_clean_lock();
        test_early_rise();
        test_missing_rise();
        test_duty_error();
        test_saturation();
        test_async_reset();
        test_dsr1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
